// File: rtl/hdr_green_merge.sv
`default_nettype none
// ============================================================================
//  Module      : hdr_green_merge
//  Description : Per-pixel HDR radiance merge, green channel. Accepts
//                1..MAX_EXP exposure samples per pixel, forms a hat-weighted
//                mean of (g(Z) + ln_gain), divides with an 18-cycle
//                restoring divider and emits one 9-bit log radiance value.
//  Ports       :
//      clk           system clock, rising edge
//      rst_n         synchronous reset, active low
//      sample_valid  sample present
//      sample_ready  block can accept a sample (ACCUM only)
//      sample_z      raw 6-bit green code (drives the hat weight)
//      sample_g      8-bit LUT response g(Z)
//      sample_gain   8-bit -ln(exposure time) offset
//      sample_last   final exposure of the pixel
//      rad_valid     result valid, held until rad_ready
//      rad_ready     consumer accepts result
//      rad_data      9-bit merged log radiance
//      err_overrun   sticky: pixel closed at MAX_EXP without sample_last
//  Revision    : 1.0  initial release
// ============================================================================
module hdr_green_merge #(
    parameter int MAX_EXP = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic [5:0] sample_z,
    input  logic [7:0] sample_g,
    input  logic [7:0] sample_gain,
    input  logic       sample_last,
    output logic       rad_valid,
    input  logic       rad_ready,
    output logic [8:0] rad_data,
    output logic       err_overrun
);

    localparam logic [3:0] c_LAST_CNT  = 4'(MAX_EXP - 1);
    localparam logic [4:0] c_DIV_STEPS = 5'd18;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t      r_state_q,     w_state_d;
    logic        r_run_q;
    logic [17:0] r_num_q,       w_num_d;
    logic [7:0]  r_den_q,       w_den_d;
    logic [8:0]  r_last_term_q, w_last_term_d;
    logic [3:0]  r_exp_cnt_q,   w_exp_cnt_d;
    logic [17:0] r_quo_q,       w_quo_d;      // dividend shifts out, quotient shifts in
    logic [7:0]  r_rem_q,       w_rem_d;
    logic [7:0]  r_div_q,       w_div_d;
    logic [4:0]  r_cnt_q,       w_cnt_d;
    logic [8:0]  r_rad_data_q,  w_rad_data_d;
    logic        r_err_q,       w_err_d;

    // Per-sample datapath
    logic [4:0]  w_weight;
    logic [8:0]  w_term;
    logic [13:0] w_prod;
    logic [17:0] w_num_acc;
    logic [7:0]  w_den_acc;
    logic        w_accept;
    logic        w_close_cnt;
    logic        w_close;

    // Divider step
    logic [8:0]  w_trial;
    logic        w_qbit;
    logic [7:0]  w_rem_step;

    assign sample_ready = r_run_q && (r_state_q == ST_ACCUM);
    assign rad_valid    = (r_state_q == ST_OUTPUT);
    assign rad_data     = r_rad_data_q;
    assign err_overrun  = r_err_q;

    always_comb begin
        // Hat weight peaks at mid-scale and falls to zero at both rails
        w_weight    = sample_z[5] ? 5'(6'd63 - sample_z) : sample_z[4:0];
        w_term      = {1'b0, sample_g} + {1'b0, sample_gain};
        w_prod      = w_weight * w_term;
        w_num_acc   = r_num_q + {4'b0, w_prod};
        w_den_acc   = r_den_q + {3'b0, w_weight};
        w_accept    = sample_valid && sample_ready;
        w_close_cnt = (r_exp_cnt_q == c_LAST_CNT);
        w_close     = w_accept && (sample_last || w_close_cnt);
    end

    always_comb begin
        w_trial = {r_rem_q, r_quo_q[17]};
        w_qbit  = (w_trial >= {1'b0, r_div_q});
        if (w_qbit) begin
            w_rem_step = 8'(w_trial - {1'b0, r_div_q});
        end else begin
            w_rem_step = w_trial[7:0];
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_num_d       = r_num_q;
        w_den_d       = r_den_q;
        w_last_term_d = r_last_term_q;
        w_exp_cnt_d   = r_exp_cnt_q;
        w_quo_d       = r_quo_q;
        w_rem_d       = r_rem_q;
        w_div_d       = r_div_q;
        w_cnt_d       = r_cnt_q;
        w_rad_data_d  = r_rad_data_q;
        w_err_d       = r_err_q;

        case (r_state_q)
            ST_ACCUM: begin
                if (w_accept) begin
                    w_num_d       = w_num_acc;
                    w_den_d       = w_den_acc;
                    w_last_term_d = w_term;
                    w_exp_cnt_d   = r_exp_cnt_q + 4'd1;
                end
                if (w_close) begin
                    // Adding den/2 turns the truncating divide into round-half-up
                    w_quo_d   = w_num_acc + {11'b0, w_den_acc[7:1]};
                    w_div_d   = w_den_acc;
                    w_rem_d   = 8'd0;
                    w_cnt_d   = 5'd0;
                    w_state_d = ST_DIVIDE;
                    if (w_close_cnt && !sample_last) begin
                        w_err_d = 1'b1;
                    end
                end
            end

            ST_DIVIDE: begin
                if (r_cnt_q != c_DIV_STEPS) begin
                    w_rem_d = w_rem_step;
                    w_quo_d = {r_quo_q[16:0], w_qbit};
                    w_cnt_d = r_cnt_q + 5'd1;
                end else begin
                    // A zero divisor yields garbage; fall back to the last term
                    w_rad_data_d = (r_den_q == 8'd0) ? r_last_term_q : r_quo_q[8:0];
                    w_state_d    = ST_OUTPUT;
                end
            end

            ST_OUTPUT: begin
                if (rad_ready) begin
                    w_num_d     = 18'd0;
                    w_den_d     = 8'd0;
                    w_exp_cnt_d = 4'd0;
                    w_state_d   = ST_ACCUM;
                end
            end

            default: begin
                w_state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= ST_ACCUM;
            r_run_q       <= 1'b0;
            r_num_q       <= 18'd0;
            r_den_q       <= 8'd0;
            r_last_term_q <= 9'd0;
            r_exp_cnt_q   <= 4'd0;
            r_quo_q       <= 18'd0;
            r_rem_q       <= 8'd0;
            r_div_q       <= 8'd0;
            r_cnt_q       <= 5'd0;
            r_rad_data_q  <= 9'd0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_run_q       <= 1'b1;
            r_num_q       <= w_num_d;
            r_den_q       <= w_den_d;
            r_last_term_q <= w_last_term_d;
            r_exp_cnt_q   <= w_exp_cnt_d;
            r_quo_q       <= w_quo_d;
            r_rem_q       <= w_rem_d;
            r_div_q       <= w_div_d;
            r_cnt_q       <= w_cnt_d;
            r_rad_data_q  <= w_rad_data_d;
            r_err_q       <= w_err_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/hdr_green_merge.md
# hdr_green_merge

Per-pixel HDR radiance merge for the green channel. It sits directly downstream of the green response LUT (6-bit green code → 8-bit log response g(Z)). For each pixel it accepts 1..MAX_EXP exposure samples and forms a hat-weighted average of (g(Z) + ln_gain). A multi-cycle restoring divider then emits one 9-bit log-radiance value per pixel to the tone-mapping stage.

## Interface
- MAX_EXP, default 3; maximum exposures per pixel, legal range 1..8.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- sample_valid  in  1  sample present.
- sample_ready  out  1  block can accept a sample.
- sample_z  in  6  raw green code, already aligned with sample_g (producer absorbs the LUT's 1-cycle latency).
- sample_g  in  8  LUT response g(Z), unsigned.
- sample_gain  in  8  unsigned −ln(exposure time) offset, same scale as g.
- sample_last  in  1  final exposure of this pixel.
- rad_valid  out  1  result valid, held until taken.
- rad_ready  in  1  consumer accepts result.
- rad_data  out  9  merged log radiance, unsigned.
- err_overrun  out  1  sticky: pixel forcibly closed at MAX_EXP samples without sample_last.

## Operation
- Sample accepted when sample_valid & sample_ready at a rising edge.
- Per accepted sample:
  - w = min(z, 63−z), 5 bits, range 0..31.
  - term = g + gain, 9 bits, range 0..510.
  - num += w*term (18-bit accumulator).
  - den += w (8-bit accumulator).
  - last_term <= term.
  - exp_cnt increments.
- Pixel closes on an accepted sample with sample_last = 1, or on an accepted sample with exp_cnt = MAX_EXP−1. In the latter case sample_last is ignored and, if it was 0, err_overrun is set.
- States:
  - ACCUM: sample_ready = 1. On close → DIVIDE, with dividend = num + (den>>1) (rounding) and divisor = den.
  - DIVIDE: sample_ready = 0. Restoring divide, one quotient bit per cycle, exactly 18 cycles, then → OUTPUT.
  - OUTPUT: rad_valid = 1. rad_data = quotient[8:0], or last_term if den = 0. On rad_ready → ACCUM, clearing num, den and exp_cnt.
- Quotient never exceeds 510 (it is a weighted mean of terms ≤ 510), so no clipping is needed.
- den = 0 (all samples at z = 0 or 63): the divider still runs its full 18 cycles; the output is last_term.
- err_overrun clears only on reset.
- Inputs during DIVIDE/OUTPUT are ignored; the producer must hold its sample.

## Timing
- Reset values:
  - sample_ready = 0 during reset, then 1 (ACCUM) from the first cycle after rst_n rises.
  - rad_valid = 0, rad_data = 0, err_overrun = 0, accumulators = 0, state = ACCUM.
- Accumulation: one sample per cycle, zero bubbles between samples of the same pixel.
- Latency: rad_valid rises 19 cycles after the cycle in which the closing sample is accepted (18 DIVIDE cycles plus 1 to enter OUTPUT).
- Backpressure: rad_valid and rad_data stay stable while rad_ready = 0.
- Throughput (rad_ready tied high): sample_ready rises the cycle after the rad handshake, giving a minimum of N+20 cycles per pixel for N samples.
- Reset asserted mid-DIVIDE or in OUTPUT aborts the pixel: all outputs go to reset values at the next edge, and no result is emitted.
- MAX_EXP = 1: every accepted sample closes the pixel. err_overrun sets whenever that sample has sample_last = 0.

## Test plan
- Single exposure z=32, g=38, gain=10, last=1 → w=31, num=1488, den=31; rad_data=48 exactly 19 cycles after acceptance, err_overrun=0.
- Three exposures:
  - (z=10, g=19, gain=40)
  - (z=40, g=45, gain=20)
  - (z=63, g=62, gain=0, last)
  - → num=2085, den=33, rad_data=(2085+16)/33=63.
- Saturated pixel: (z=0, g=0, gain=50), then (z=63, g=62, gain=7, last) → den=0, rad_data=69 (last_term), latency still 19.
- Overrun with MAX_EXP=3: three samples with last=0 → pixel closes after the third, result emitted, err_overrun=1 and stays 1 after a subsequent normal pixel.
- Backpressure: rad_ready low for 5 cycles after rad_valid → rad_data unchanged and sample_ready=0 throughout; sample_ready=1 the cycle after the handshake.
- Reset during the 10th DIVIDE cycle → next edge: rad_valid=0, rad_data=0, sample_ready=0 while rst_n low; the following pixel (z=32, g=38, gain=10) yields 48 with no stale result.
